// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state enumeration.
// Also holds the byte-lane mask helper used by the write path.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    // Little-endian lane selection; sizes above word never reach the write path.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << offset;
            HSIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_bytelane_mem.sv
// DEPTH x 32 storage with per-byte write enables, asynchronous read
// and asynchronous clear of every word.
module ahb_bytelane_mem #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (we[l]) begin
                    mem_reg[addr][8*l +: 8] <= wdata[8*l +: 8];
                end
            end
        end
    end

    assign rdata = mem_reg[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: configurable wait states, two-cycle ERROR response
// for out-of-range or misaligned transfers, byte-lane writes.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [12:0] LIMIT     = 13'(DEPTH * 4);
    localparam logic [1:0]  WAIT_LOAD = 2'(WAIT_STATES);

    slave_state_t  state_reg, state_next;
    logic [1:0]    wait_cnt_reg, wait_cnt_next;
    logic [AW+1:0] addr_reg;
    logic          write_reg;
    logic [2:0]    size_reg;

    logic          ready_state;
    logic          accept;
    logic          addr_err;
    logic [3:0]    mem_we;
    logic [31:0]   mem_rdata;

    logic          unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HADDR[31:12]};

    // Only states that present HREADYOUT=1 can take a new address phase.
    assign ready_state = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
    assign accept = HSEL && HREADY && ready_state &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    assign addr_err = ({1'b0, HADDR[11:0]} >= LIMIT) ||
                      (HSIZE > HSIZE_WORD) ||
                      ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 2'd1;
                if (wait_cnt_reg <= 2'd1) begin
                    state_next = ST_DATA;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
                if (accept) begin
                    if (addr_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = ready_state;
        HRESP     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA    = ((state_reg == ST_DATA) && !write_reg) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            size_reg  <= HSIZE_BYTE;
        end else if (accept) begin
            addr_reg  <= HADDR[AW+1:0];
            write_reg <= HWRITE;
            size_reg  <= HSIZE;
        end
    end

    // Errored transfers never reach ST_DATA, so they cannot write.
    assign mem_we = ((state_reg == ST_DATA) && write_reg) ? lane_mask(size_reg, addr_reg[1:0]) : 4'b0000;

    ahb_bytelane_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (HCLK),
        .rst   (HRESET),
        .we    (mem_we),
        .addr  (addr_reg[AW+1:2]),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter DEPTH, default 16, meaning the number of 32-bit storage words (power of 2, 4..64).
REQ-002 Parameter WAIT_STATES, default 1, meaning the wait cycles inserted per OKAY transfer (0..3).
REQ-003 HCLK  in  1  is the single clock; all state SHALL change on the rising edge.
REQ-004 HRESET  in  1  is the reset: asynchronous, active-high.
REQ-005 HSEL  in  1  is the slave select from the decoder.
REQ-006 HADDR  in  32  is the transfer address.
REQ-007 HTRANS  in  2  is the transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 HWRITE  in  1  selects the direction: 1 = write, 0 = read.
REQ-009 HSIZE  in  3  is the transfer size: 000 byte, 001 halfword, 010 word.
REQ-010 HBURST  in  3  and HPROT  in  4  are accepted and ignored.
REQ-011 HWDATA  in  32  is the write data, valid in the data phase.
REQ-012 HREADY  in  1  is the bus-level ready (address phase qualifier).
REQ-013 HREADYOUT  out  1  is the slave ready; 0 inserts a wait state.
REQ-014 HRESP  out  2  is the response: OKAY=00, ERROR=01.
REQ-015 HRDATA  out  32  is the read data.

Function
REQ-016 The block SHALL accept a transfer on an edge where HSEL=1, HREADY=1 and HTRANS[1]=1; at that edge it SHALL latch HADDR, HWRITE and HSIZE.
REQ-017 IDLE, BUSY or HSEL=0 with HREADY=1 SHALL give a zero-wait OKAY response and SHALL have no storage effect.
REQ-018 The block SHALL flag a transfer as an error when any of the following holds: HADDR[11:0] >= DEPTH*4; HSIZE > 010; a halfword with HADDR[0]=1; a word with HADDR[1:0] != 00.
REQ-019 The state machine SHALL have the states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-020 Accept with error SHALL go to ERR1. Accept with WAIT_STATES>0 SHALL go to WAIT. Accept with WAIT_STATES=0 SHALL go to DATA.
REQ-021 WAIT SHALL drive HREADYOUT=0 and HRESP=OKAY, and SHALL last exactly WAIT_STATES cycles (down-counter), then go to DATA.
REQ-022 DATA SHALL drive HREADYOUT=1 and HRESP=OKAY. From DATA the block SHALL go to the next accepted transfer's state if one is accepted on the same edge, otherwise to IDLE.
REQ-023 ERR1 SHALL drive HREADYOUT=0 and HRESP=ERROR. ERR2 SHALL drive HREADYOUT=1 and HRESP=ERROR. ERR2 SHALL follow ERR1 unconditionally, and from ERR2 the next state SHALL be chosen as from DATA.
REQ-024 An errored transfer SHALL never modify storage, and HRDATA SHALL be 0 during ERR1 and ERR2.
REQ-025 A write SHALL commit on the edge ending DATA, updating only the byte lanes selected by the latched HSIZE and HADDR[1:0] (little-endian: byte n = bits 8n+7:8n).
REQ-026 During a read DATA cycle, HRDATA SHALL equal the full word mem[latched HADDR[log2(DEPTH)+1:2]], driven combinationally from storage; otherwise HRDATA SHALL be 0.
REQ-027 Back-to-back write then read of the same word, with the read's address phase coinciding with the write's data phase, SHALL return the newly written data.
REQ-028 In IDLE the block SHALL drive HREADYOUT=1 and HRESP=OKAY.

Reset
REQ-029 While HRESET=1 the block SHALL be in state IDLE with HREADYOUT=1, HRESP=00, HRDATA=0, wait counter 0 and all storage words 0.
REQ-030 Reset asserted mid-WAIT or mid-ERR1 SHALL abort the transfer without committing any write; the first accept SHALL be possible on the first edge after HRESET falls.

Structure
REQ-031 Package ahb_pkg SHALL hold the HTRANS, HRESP and HSIZE encodings and the slave state enumeration.
REQ-032 Storage SHALL be the sub-module ahb_bytelane_mem: DEPTH x 32 with a 4-bit byte write-enable, asynchronous read and reset-to-zero.

Verification
REQ-033 Scenario: WAIT_STATES=1, write word 0xA5A5A5A5 to 0x4000_0000, then read 0x4000_0000 -> one HREADYOUT=0 cycle per transfer, HRESP=00 throughout, HRDATA=0xA5A5A5A5.
REQ-034 Scenario: byte write of 0x0000EF00 (lane 1) to 0x4000_0001 over 0xA5A5A5A5 -> read of 0x4000_0000 returns 0xA5A5EFA5.
REQ-035 Scenario: WAIT_STATES=0, write 0xDEADBEEF to 0x4000_0004 immediately followed by a read of 0x4000_0004 -> HRDATA=0xDEADBEEF in the cycle after the write data phase, with no wait states.
REQ-036 Scenario: read of 0x4000_0040 (DEPTH=16) -> HRESP=01 for two cycles with HREADYOUT 0 then 1, HRDATA=0, storage unchanged.
REQ-037 Scenario: word write to 0x4000_0002 -> two-cycle ERROR; a subsequent read of 0x4000_0000 still returns the prior value.
REQ-038 Scenario: HRESET pulsed during WAIT of a write of 0x12345678 -> HREADYOUT=1 immediately, and a later read returns 0x00000000.
